// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, flush bubble insertion and
// memory-stall hold; also keeps a saturating count of injected bubbles.
module id_ex_hazard_stage #(
    parameter int XLEN    = 32,
    parameter int CTRL_W  = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic [4:0]         id_rd,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [CTRL_W-1:0]  id_ctrl,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               flush_ex,
    input  logic               mem_stall,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic [4:0]         ex_rd,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic               ex_regwrite,
    output logic               ex_memread,
    output logic               pc_write,
    output logic               if_id_write,
    output logic [1:0]         state,
    output logic [COUNT_W-1:0] bubble_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t state_q;
    logic   hazard;
    logic   insert_bubble;

    // A load in EX whose destination is read by ID cannot be forwarded in time;
    // x0 is never a real dependency.
    always_comb begin
        hazard = id_valid & ex_valid & ex_memread & (ex_rd != 5'd0) &
                 ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                  (id_uses_rs2 & (id_rs2 == ex_rd)));
        insert_bubble = flush_ex | hazard;
    end

    // A wrong-path flush lets the front end advance; a load-use stall must not.
    always_comb begin
        pc_write = 1'b1;
        if (reset)
            pc_write = 1'b1;
        else if (mem_stall)
            pc_write = 1'b0;
        else if (flush_ex)
            pc_write = 1'b1;
        else if (hazard)
            pc_write = 1'b0;
        if_id_write = pc_write;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            state_q      <= RUN;
            bubble_count <= '0;
        end else if (mem_stall) begin
            state_q <= HOLD;
        end else if (insert_bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_ctrl     <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            state_q     <= BUBBLE;
            if (bubble_count != {COUNT_W{1'b1}})
                bubble_count <= bubble_count + 1'b1;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_ctrl     <= id_ctrl;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            state_q     <= RUN;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Scoreboard bench: directed ID/EX vectors push hand-computed expectations,
// a monitor pops and compares them against the DUT each cycle.
module tb_id_ex_hazard_stage;

    localparam int XLEN    = 32;
    localparam int CTRL_W  = 8;
    localparam int COUNT_W = 2;

    logic               clk;
    logic               reset;
    logic               id_valid;
    logic [XLEN-1:0]    id_pc;
    logic [4:0]         id_rs1;
    logic [4:0]         id_rs2;
    logic               id_uses_rs1;
    logic               id_uses_rs2;
    logic [4:0]         id_rd;
    logic [XLEN-1:0]    id_rs1_data;
    logic [XLEN-1:0]    id_rs2_data;
    logic [XLEN-1:0]    id_imm;
    logic [CTRL_W-1:0]  id_ctrl;
    logic               id_regwrite;
    logic               id_memread;
    logic               flush_ex;
    logic               mem_stall;
    logic               ex_valid;
    logic [XLEN-1:0]    ex_pc;
    logic [4:0]         ex_rs1;
    logic [4:0]         ex_rs2;
    logic [4:0]         ex_rd;
    logic [XLEN-1:0]    ex_rs1_data;
    logic [XLEN-1:0]    ex_rs2_data;
    logic [XLEN-1:0]    ex_imm;
    logic [CTRL_W-1:0]  ex_ctrl;
    logic               ex_regwrite;
    logic               ex_memread;
    logic               pc_write;
    logic               if_id_write;
    logic [1:0]         state;
    logic [COUNT_W-1:0] bubble_count;

    id_ex_hazard_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush_ex(flush_ex), .mem_stall(mem_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .pc_write(pc_write), .if_id_write(if_id_write),
        .state(state), .bubble_count(bubble_count)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
        logic        rw;
        logic        mr;
    } instr_t;

    typedef struct {
        int          step;
        logic        pw;
        logic        iw;
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
        logic        rw;
        logic        mr;
        logic [1:0]  st;
        logic [1:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    instr_t lw5, add, lw0, use0, addi5, use5, fl40, add2, nouse;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic u1, input logic u2,
                                  input logic [4:0] rd, input logic [7:0] ctrl,
                                  input logic rw, input logic mr);
        instr_t i;
        i.valid = 1'b1; i.pc = pc; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2;
        i.rd = rd; i.ctrl = ctrl; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    task automatic applyStimulus(input instr_t i, input logic rst, input logic fl,
                                 input logic stl, input logic pw, input logic v,
                                 input logic [31:0] pc, input logic [4:0] rs1,
                                 input logic [4:0] rd, input logic [7:0] ctrl,
                                 input logic rw, input logic mr, input logic [1:0] st,
                                 input logic [1:0] cnt);
        exp_t e;
        @(negedge clk);
        reset       = rst;
        id_valid    = i.valid;
        id_pc       = i.pc;
        id_rs1      = i.rs1;
        id_rs2      = i.rs2;
        id_uses_rs1 = i.u1;
        id_uses_rs2 = i.u2;
        id_rd       = i.rd;
        id_rs1_data = i.pc ^ 32'hA5A5_0000;
        id_rs2_data = ~i.pc;
        id_imm      = i.pc;
        id_ctrl     = i.ctrl;
        id_regwrite = i.rw;
        id_memread  = i.mr;
        flush_ex    = fl;
        mem_stall   = stl;
        #1;
        step_no++;
        e.step = step_no; e.pw = pw; e.iw = pw; e.v = v; e.pc = pc; e.rs1 = rs1;
        e.rd = rd; e.ctrl = ctrl; e.rw = rw; e.mr = mr; e.st = st; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic cmp(input int step, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL step %0d %s: got 0x%0h, expected 0x%0h", step, name, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e, input logic pw, input logic iw);
        cmp(e.step, "pc_write",     {31'd0, pw},          {31'd0, e.pw});
        cmp(e.step, "if_id_write",  {31'd0, iw},          {31'd0, e.iw});
        cmp(e.step, "ex_valid",     {31'd0, ex_valid},    {31'd0, e.v});
        cmp(e.step, "ex_pc",        ex_pc,                e.pc);
        cmp(e.step, "ex_imm",       ex_imm,               e.pc);
        cmp(e.step, "ex_rs1",       {27'd0, ex_rs1},      {27'd0, e.rs1});
        cmp(e.step, "ex_rd",        {27'd0, ex_rd},       {27'd0, e.rd});
        cmp(e.step, "ex_ctrl",      {24'd0, ex_ctrl},     {24'd0, e.ctrl});
        cmp(e.step, "ex_regwrite",  {31'd0, ex_regwrite}, {31'd0, e.rw});
        cmp(e.step, "ex_memread",   {31'd0, ex_memread},  {31'd0, e.mr});
        cmp(e.step, "state",        {30'd0, state},       {30'd0, e.st});
        cmp(e.step, "bubble_count", {30'd0, bubble_count}, {30'd0, e.cnt});
    endtask

    // Monitor: enables are sampled mid-cycle, registered fields just after the edge.
    initial begin
        logic pw_s, iw_s;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                pw_s = pc_write;
                iw_s = if_id_write;
                @(posedge clk);
                #1;
                e = sb.pop_front();
                checkOutput(e, pw_s, iw_s);
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b1; id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_rd = '0; id_rs1_data = '0;
        id_rs2_data = '0; id_imm = '0; id_ctrl = '0; id_regwrite = 1'b0;
        id_memread = 1'b0; flush_ex = 1'b0; mem_stall = 1'b0;

        lw5   = mk(32'h10, 5'd2, 5'd0, 1, 0, 5'd5,  8'h11, 1, 1);
        add   = mk(32'h14, 5'd5, 5'd7, 1, 1, 5'd6,  8'h22, 1, 0);
        lw0   = mk(32'h18, 5'd1, 5'd0, 1, 0, 5'd0,  8'h33, 1, 1);
        use0  = mk(32'h1C, 5'd0, 5'd0, 1, 1, 5'd8,  8'h44, 1, 0);
        addi5 = mk(32'h20, 5'd1, 5'd0, 1, 0, 5'd5,  8'h55, 1, 0);
        use5  = mk(32'h24, 5'd5, 5'd0, 1, 0, 5'd9,  8'h66, 1, 0);
        fl40  = mk(32'h40, 5'd3, 5'd4, 1, 1, 5'd10, 8'h77, 1, 0);
        add2  = mk(32'h28, 5'd7, 5'd5, 1, 1, 5'd11, 8'h88, 1, 0);
        nouse = mk(32'h2C, 5'd5, 5'd5, 0, 0, 5'd12, 8'h99, 0, 0);

        // args: instr, reset, flush, stall | pw, ex_valid, pc, rs1, rd, ctrl, rw, mr, state, count
        applyStimulus(lw5,   1, 0, 0,  1, 0, 32'h00, 0, 0,  8'h00, 0, 0, 0, 0);
        applyStimulus(lw5,   0, 0, 0,  1, 1, 32'h10, 2, 5,  8'h11, 1, 1, 0, 0);
        applyStimulus(add,   0, 0, 0,  0, 0, 32'h00, 0, 0,  8'h00, 0, 0, 1, 1);
        applyStimulus(add,   0, 0, 0,  1, 1, 32'h14, 5, 6,  8'h22, 1, 0, 0, 1);
        applyStimulus(lw0,   0, 0, 0,  1, 1, 32'h18, 1, 0,  8'h33, 1, 1, 0, 1);
        applyStimulus(use0,  0, 0, 0,  1, 1, 32'h1C, 0, 8,  8'h44, 1, 0, 0, 1);
        applyStimulus(addi5, 0, 0, 0,  1, 1, 32'h20, 1, 5,  8'h55, 1, 0, 0, 1);
        applyStimulus(use5,  0, 0, 0,  1, 1, 32'h24, 5, 9,  8'h66, 1, 0, 0, 1);
        applyStimulus(fl40,  0, 1, 0,  1, 0, 32'h00, 0, 0,  8'h00, 0, 0, 1, 2);
        applyStimulus(lw5,   0, 0, 0,  1, 1, 32'h10, 2, 5,  8'h11, 1, 1, 0, 2);
        for (int k = 0; k < 3; k++)
            applyStimulus(add2, 0, 0, 1, 0, 1, 32'h10, 2, 5, 8'h11, 1, 1, 2, 2);
        applyStimulus(add2,  0, 0, 0,  0, 0, 32'h00, 0, 0,  8'h00, 0, 0, 1, 3);
        applyStimulus(add2,  0, 0, 0,  1, 1, 32'h28, 7, 11, 8'h88, 1, 0, 0, 3);
        applyStimulus(add2,  0, 1, 0,  1, 0, 32'h00, 0, 0,  8'h00, 0, 0, 1, 3);
        applyStimulus(add2,  0, 1, 0,  1, 0, 32'h00, 0, 0,  8'h00, 0, 0, 1, 3);
        applyStimulus(lw5,   0, 0, 0,  1, 1, 32'h10, 2, 5,  8'h11, 1, 1, 0, 3);
        applyStimulus(nouse, 0, 0, 0,  1, 1, 32'h2C, 5, 12, 8'h99, 0, 0, 0, 3);
        applyStimulus(lw5,   0, 0, 0,  1, 1, 32'h10, 2, 5,  8'h11, 1, 1, 0, 3);
        applyStimulus(add,   0, 1, 1,  0, 1, 32'h10, 2, 5,  8'h11, 1, 1, 2, 3);
        applyStimulus(add,   1, 0, 1,  1, 0, 32'h00, 0, 0,  8'h00, 0, 0, 0, 0);
        applyStimulus(add,   0, 0, 0,  1, 1, 32'h14, 5, 6,  8'h22, 1, 0, 0, 0);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_assert++;
            n_fail++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
